// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared scan-state enum, blank constant and hex-to-segment table
package seg_pkg;

    typedef enum logic [1:0] {
        BLANK_L = 2'd0,
        SHOW_L  = 2'd1,
        BLANK_R = 2'd2,
        SHOW_R  = 2'd3
    } seg_state_e;

    localparam logic [0:6] SEG_OFF = 7'b1111111;

    // Active-low patterns; leftmost bit of each entry is SEG_C[0] (top segment).
    localparam logic [0:15][0:6] HEX_SEG = {
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - digit-pair update handshake between producer and scan controller
interface seg_scan_ctrl_if;
    logic       upd_valid;
    logic [7:0] upd_data;
    logic       upd_ready;

    modport master (output upd_valid, output upd_data, input  upd_ready);
    modport slave  (input  upd_valid, input  upd_data, output upd_ready);
endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex digit to active-low 7-segment pattern
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [0:6] seg_o
);

    assign seg_o = HEX_SEG[digit_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - two-digit multiplexed 7-segment scanner with blanking and tear-free updates
// Optional build macro: LEADING_ZERO_BLANK_EN (blank the left digit when it is zero).
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DWELL_CYCLES = 8192,
    parameter int BLANK_CYCLES = 64
) (
    input  logic             CLK,
    input  logic             RST_N,
    seg_scan_ctrl_if.slave   upd,
    output logic [0:6]       SEG_C,
    output logic             SEG_AN,
    output logic             frame_tick
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    seg_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       disp_q, disp_d;
    logic [7:0]       pend_q, pend_d;
    logic             pend_full_q, pend_full_d;

    logic             cnt_last;
    logic             boundary;
    logic             xfer;
    logic [3:0]       digit;
    logic [0:6]       digit_seg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= BLANK_L;
            cnt_q       <= '0;
            disp_q      <= 8'h00;
            pend_q      <= 8'h00;
            pend_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
        end
    end

    assign upd.upd_ready = !pend_full_q;
    assign xfer          = upd.upd_valid && !pend_full_q;
    assign digit         = (state_q == SHOW_R) ? disp_q[3:0] : disp_q[7:4];

    seg7_decode u_decode (
        .digit_i (digit),
        .seg_o   (digit_seg)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        SEG_C       = SEG_OFF;
        SEG_AN      = 1'b0;

        cnt_last = ((state_q == SHOW_L) || (state_q == SHOW_R)) ? (cnt_q == DWELL_LAST)
                                                                : (cnt_q == BLANK_LAST);
        boundary   = (state_q == SHOW_R) && cnt_last;
        frame_tick = boundary;

        if (cnt_last) begin
            cnt_d = '0;
            case (state_q)
                BLANK_L: state_d = SHOW_L;
                SHOW_L:  state_d = BLANK_R;
                BLANK_R: state_d = SHOW_R;
                default: state_d = BLANK_L;
            endcase
        end

        // Pending is full on the boundary only if it filled in an earlier cycle,
        // so a boundary-cycle transfer waits for the following frame.
        if (boundary && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pend_d      = upd.upd_data;
            pend_full_d = 1'b1;
        end

        case (state_q)
            SHOW_L: begin
`ifdef LEADING_ZERO_BLANK_EN
                SEG_C = (disp_q[7:4] == 4'h0) ? SEG_OFF : digit_seg;
`else
                SEG_C = digit_seg;
`endif
            end
            BLANK_R: SEG_AN = 1'b1;
            SHOW_R: begin
                SEG_AN = 1'b1;
                SEG_C  = digit_seg;
            end
            default: SEG_C = SEG_OFF;
        endcase
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl (DWELL=4, BLANK=2)
module tb_seg_scan_ctrl;

    localparam logic [6:0] OFF = 7'b1111111;
    localparam logic [6:0] P0  = 7'b0000001;
    localparam logic [6:0] P1  = 7'b1001111;
    localparam logic [6:0] P2  = 7'b0010010;
    localparam logic [6:0] P3  = 7'b0000110;
    localparam logic [6:0] P4  = 7'b1001100;
    localparam logic [6:0] P5  = 7'b0100100;
    localparam logic [6:0] P7  = 7'b0001111;
    localparam logic [6:0] PA  = 7'b0001000;
    localparam logic [6:0] PF  = 7'b0111000;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZL  = OFF;
`else
    localparam logic [6:0] ZL  = P0;
`endif

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic [6:0] seg;
        logic       an;
        logic       tick;
        logic       rdy;
    } vec_t;

    logic       CLK;
    logic       RST_N;
    logic [0:6] SEG_C;
    logic       SEG_AN;
    logic       frame_tick;

    int cmp_cnt = 0;
    int err_cnt = 0;

    seg_scan_ctrl_if upd_if ();

    seg_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .upd        (upd_if.slave),
        .SEG_C      (SEG_C),
        .SEG_AN     (SEG_AN),
        .frame_tick (frame_tick)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        while (frame_tick !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({name, "_tick_reached"}, {7'd0, frame_tick}, 8'd1);
    endtask

    // Checks frame cycles start..12 (1-based); returns positioned at cycle 1 of the next frame.
    task automatic check_frame(input string name, input logic [6:0] exp_l,
                               input logic [6:0] exp_r, input int start);
        logic [6:0] es;
        logic       ea;
        for (int c = start; c <= 12; c++) begin
            if (c <= 2)      begin es = OFF;   ea = 1'b0; end
            else if (c <= 6) begin es = exp_l; ea = 1'b0; end
            else if (c <= 8) begin es = OFF;   ea = 1'b1; end
            else             begin es = exp_r; ea = 1'b1; end
            chk($sformatf("%s_c%0d_seg", name, c), {1'b0, SEG_C}, {1'b0, es});
            chk($sformatf("%s_c%0d_an", name, c), {7'd0, SEG_AN}, {7'd0, ea});
            chk($sformatf("%s_c%0d_tick", name, c), {7'd0, frame_tick}, {7'd0, (c == 12)});
            step();
        end
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1'b0, 8'h00, OFF, 1'b0, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 8'h00, OFF, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 8'h00, ZL,  1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 8'h00, ZL,  1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 8'h00, ZL,  1'b0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 8'h00, ZL,  1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 8'h00, OFF, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 8'h00, OFF, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 8'h00, P0,  1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 8'h00, P0,  1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 8'h00, P0,  1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 8'h00, P0,  1'b1, 1'b1, 1'b1};

        RST_N            = 1'b0;
        upd_if.upd_valid = 1'b0;
        upd_if.upd_data  = 8'h00;
        #12;
        chk("rst_seg", {1'b0, SEG_C}, {1'b0, OFF});
        chk("rst_an", {7'd0, SEG_AN}, 8'd0);
        chk("rst_rdy", {7'd0, upd_if.upd_ready}, 8'd1);
        chk("rst_tick", {7'd0, frame_tick}, 8'd0);

        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < 12; i++) begin
            upd_if.upd_valid = tbl[i].vld;
            upd_if.upd_data  = tbl[i].data;
            chk($sformatf("tbl%0d_seg", i), {1'b0, SEG_C}, {1'b0, tbl[i].seg});
            chk($sformatf("tbl%0d_an", i), {7'd0, SEG_AN}, {7'd0, tbl[i].an});
            chk($sformatf("tbl%0d_tick", i), {7'd0, frame_tick}, {7'd0, tbl[i].tick});
            chk($sformatf("tbl%0d_rdy", i), {7'd0, upd_if.upd_ready}, {7'd0, tbl[i].rdy});
            step();
        end

        // Mid-frame update of 3A offered in SHOW_L
        step(); step();
        upd_if.upd_valid = 1'b1;
        upd_if.upd_data  = 8'h3A;
        chk("mid_rdy_before", {7'd0, upd_if.upd_ready}, 8'd1);
        step();
        upd_if.upd_valid = 1'b0;
        chk("mid_rdy_after", {7'd0, upd_if.upd_ready}, 8'd0);
        chk("mid_left_unchanged", {1'b0, SEG_C}, {1'b0, ZL});
        repeat (5) step();
        chk("mid_right_unchanged", {1'b0, SEG_C}, {1'b0, P0});
        wait_tick("mid");
        chk("mid_rdy_at_tick", {7'd0, upd_if.upd_ready}, 8'd0);
        step();
        chk("mid_rdy_reopen", {7'd0, upd_if.upd_ready}, 8'd1);
        check_frame("mid_3A", P3, PA, 1);

        // Back-pressure: 12 accepted, 34 held until the cycle after the boundary
        upd_if.upd_valid = 1'b1;
        upd_if.upd_data  = 8'h12;
        chk("bp_rdy_12", {7'd0, upd_if.upd_ready}, 8'd1);
        step();
        upd_if.upd_data  = 8'h34;
        chk("bp_rdy_blocked", {7'd0, upd_if.upd_ready}, 8'd0);
        wait_tick("bp");
        chk("bp_rdy_at_tick", {7'd0, upd_if.upd_ready}, 8'd0);
        step();
        chk("bp_rdy_34", {7'd0, upd_if.upd_ready}, 8'd1);
        step();
        upd_if.upd_valid = 1'b0;
        chk("bp_rdy_full_34", {7'd0, upd_if.upd_ready}, 8'd0);
        check_frame("bp_12", P1, P2, 2);
        check_frame("bp_34", P3, P4, 1);

        // Transfer on the boundary cycle is deferred one frame
        wait_tick("bnd");
        upd_if.upd_valid = 1'b1;
        upd_if.upd_data  = 8'h5F;
        chk("bnd_rdy", {7'd0, upd_if.upd_ready}, 8'd1);
        step();
        upd_if.upd_valid = 1'b0;
        chk("bnd_rdy_full", {7'd0, upd_if.upd_ready}, 8'd0);
        check_frame("bnd_still_34", P3, P4, 1);
        check_frame("bnd_5F", P5, PF, 1);

        // Reset during SHOW_R with 77 pending
        upd_if.upd_valid = 1'b1;
        upd_if.upd_data  = 8'h77;
        step();
        upd_if.upd_valid = 1'b0;
        repeat (7) step();
        chk("mrst_pre_seg", {1'b0, SEG_C}, {1'b0, PF});
        chk("mrst_pre_an", {7'd0, SEG_AN}, 8'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mrst_seg", {1'b0, SEG_C}, {1'b0, OFF});
        chk("mrst_an", {7'd0, SEG_AN}, 8'd0);
        chk("mrst_rdy", {7'd0, upd_if.upd_ready}, 8'd1);
        chk("mrst_tick", {7'd0, frame_tick}, 8'd0);
        step();
        RST_N = 1'b1;
        chk("mrst_rdy_rel", {7'd0, upd_if.upd_ready}, 8'd1);
        check_frame("mrst_f1", ZL, P0, 1);
        check_frame("mrst_f2", ZL, P0, 1);

        // Leading zero: display 07
        upd_if.upd_valid = 1'b1;
        upd_if.upd_data  = 8'h07;
        step();
        upd_if.upd_valid = 1'b0;
        check_frame("lz_pre", ZL, P0, 2);
        check_frame("lz_07", ZL, P7, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
